// File: rtl/mux_serial_sequencer.sv
// Upstream controller for an 8:1 mux: latches one word per handshake, then walks the
// mux select through all eight positions, returning the mux output as a serial stream.
module mux_serial_sequencer #(
   parameter bit MSB_FIRST = 1'b0,
   parameter int IDLE_GAP  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] mux_i,
   output logic [2:0] mux_s,
   input  logic       mux_y,
   output logic       ser_out,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_last,
   output logic       busy
);

   localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [3:0] GAP_LOAD  = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t     state_reg;
   logic [3:0] gap_cnt_reg;
   logic [2:0] beat_cnt_reg;
   logic [7:0] mux_i_reg;
   logic [2:0] mux_s_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         gap_cnt_reg  <= 4'd0;
         beat_cnt_reg <= 3'd0;
         mux_i_reg    <= 8'h00;
         mux_s_reg    <= START_IDX;
      end else begin
         case (state_reg)
            IDLE: begin
               mux_s_reg <= START_IDX;
               if (in_valid) begin
                  mux_i_reg    <= in_data;
                  beat_cnt_reg <= 3'd0;
                  state_reg    <= SEND;
               end
            end
            SEND: begin
               // Without acceptance every register holds, keeping ser_out stable.
               if (ser_ready) begin
                  if (beat_cnt_reg == 3'd7) begin
                     mux_s_reg <= START_IDX;
                     if (IDLE_GAP > 0) begin
                        gap_cnt_reg <= GAP_LOAD;
                        state_reg   <= GAP;
                     end else begin
                        state_reg <= IDLE;
                     end
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 3'd1;
                     mux_s_reg    <= MSB_FIRST ? (mux_s_reg - 3'd1) : (mux_s_reg + 3'd1);
                  end
               end
            end
            GAP: begin
               if (gap_cnt_reg == 4'd0) begin
                  state_reg <= IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 4'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Handshake flags are masked by rst so nothing is offered or accepted during reset.
   assign in_ready  = !rst && (state_reg == IDLE);
   assign ser_valid = !rst && (state_reg == SEND);
   assign ser_last  = ser_valid && (beat_cnt_reg == 3'd7);
   assign busy      = !rst && (state_reg != IDLE);
   assign ser_out   = mux_y;
   assign mux_i     = mux_i_reg;
   assign mux_s     = mux_s_reg;

endmodule

// File: tb/tb_mux_serial_sequencer.sv
// Bench for mux_serial_sequencer: three instances (LSB-first, MSB-first, idle gap of 2)
// each driving a behavioural 8:1 mux, checked against a per-word bit-order model.
module tb_mux_serial_sequencer;

   logic       clk;
   logic       rst       [3];
   logic [7:0] in_data   [3];
   logic       in_valid  [3];
   logic       in_ready  [3];
   logic [7:0] mux_i     [3];
   logic [2:0] mux_s     [3];
   logic       mux_y     [3];
   logic       ser_out   [3];
   logic       ser_valid [3];
   logic       ser_ready [3];
   logic       ser_last  [3];
   logic       busy      [3];

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mux_serial_sequencer #(
         .MSB_FIRST (gi == 1),
         .IDLE_GAP  ((gi == 2) ? 2 : 0)
      ) dut (
         .clk       (clk),
         .rst       (rst[gi]),
         .in_data   (in_data[gi]),
         .in_valid  (in_valid[gi]),
         .in_ready  (in_ready[gi]),
         .mux_i     (mux_i[gi]),
         .mux_s     (mux_s[gi]),
         .mux_y     (mux_y[gi]),
         .ser_out   (ser_out[gi]),
         .ser_valid (ser_valid[gi]),
         .ser_ready (ser_ready[gi]),
         .ser_last  (ser_last[gi]),
         .busy      (busy[gi])
      );
      assign mux_y[gi] = mux_i[gi][mux_s[gi]];
   end

   function automatic bit msb_of(input int d);
      return d == 1;
   endfunction

   function automatic int gap_of(input int d);
      return (d == 2) ? 2 : 0;
   endfunction

   // Beat k of a word selects bit k (LSB first) or bit 7-k (MSB first).
   function automatic logic [2:0] sel_at(input int d, input int k);
      return msb_of(d) ? 3'(7 - k) : 3'(k);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: ser_ready always high; 1: random; 2: three stall cycles on beat index 3.
   task automatic send_word(input int d, input logic [7:0] w, input int mode, input bit hold);
      int k, cyc, stall;
      bit rdy, got;
      logic [2:0] sel;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("in_ready_wait", 32'(got), 32'd1);
      if (!got) return;
      in_valid[d] = 1'b1;
      in_data[d]  = w;
      @(posedge clk); #1;
      in_valid[d] = hold;
      if (hold) in_data[d] = 8'($urandom);
      k = 0; cyc = 0; stall = 0;
      while (k < 8 && cyc < 200) begin
         case (mode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            default: begin
               if (k == 3 && stall < 3) begin
                  rdy = 1'b0;
                  stall++;
               end else begin
                  rdy = 1'b1;
               end
            end
         endcase
         ser_ready[d] = rdy;
         sel = sel_at(d, k);
         @(negedge clk);
         check("ser_valid", 32'(ser_valid[d]), 32'd1);
         check("in_ready_send", 32'(in_ready[d]), 32'd0);
         check("busy_send", 32'(busy[d]), 32'd1);
         check("mux_s", 32'(mux_s[d]), 32'(sel));
         check("ser_out", 32'(ser_out[d]), 32'(w[sel]));
         check("ser_last", 32'(ser_last[d]), 32'(k == 7));
         check("mux_i_held", 32'(mux_i[d]), 32'(w));
         $display("[TB] dut%0d word=%02h beat=%0d sel=%0d bit=%0b ready=%0b", d, w, k, mux_s[d], ser_out[d], rdy);
         @(posedge clk); #1;
         if (rdy) k++;
         cyc++;
         if (hold) in_data[d] = 8'($urandom);
      end
      check("beats_done", 32'(k), 32'd8);
      in_valid[d]  = 1'b0;
      ser_ready[d] = 1'($urandom_range(0, 1));
      for (int g = 0; g < gap_of(d); g++) begin
         @(negedge clk);
         check("in_ready_gap", 32'(in_ready[d]), 32'd0);
         check("ser_valid_gap", 32'(ser_valid[d]), 32'd0);
         check("ser_last_gap", 32'(ser_last[d]), 32'd0);
         check("busy_gap", 32'(busy[d]), 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("in_ready_back", 32'(in_ready[d]), 32'd1);
      check("ser_valid_idle", 32'(ser_valid[d]), 32'd0);
      check("busy_idle", 32'(busy[d]), 32'd0);
      check("mux_s_idle", 32'(mux_s[d]), 32'(sel_at(d, 0)));
      @(posedge clk); #1;
      ser_ready[d] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; in_data[d] = 8'h00; in_valid[d] = 1'b0; ser_ready[d] = 1'b0;
      end
      @(posedge clk); #1;

      // T1: reset held three cycles, with in_valid/ser_ready wiggling to show they are ignored.
      for (int c = 0; c < 3; c++) begin
         for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'($urandom_range(0, 1));
            ser_ready[d] = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            check("rst_in_ready", 32'(in_ready[d]), 32'd0);
            check("rst_ser_valid", 32'(ser_valid[d]), 32'd0);
            check("rst_ser_last", 32'(ser_last[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_mux_s", 32'(mux_s[d]), 32'(sel_at(d, 0)));
            check("rst_mux_i", 32'(mux_i[d]), 32'd0);
         end
         @(posedge clk); #1;
      end
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b0; in_valid[d] = 1'b0; ser_ready[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) check("post_rst_in_ready", 32'(in_ready[d]), 32'd1);
      @(posedge clk); #1;

      // T2..T5: directed words.
      send_word(0, 8'hC1, 0, 1'b0);
      send_word(1, 8'hC1, 0, 1'b0);
      send_word(0, 8'hA5, 2, 1'b0);
      send_word(0, 8'h3C, 0, 1'b1);
      send_word(0, 8'h5A, 1, 1'b0);

      // T6: reset after four accepted beats.
      ser_ready[0] = 1'b1;
      @(negedge clk);
      check("t6_in_ready", 32'(in_ready[0]), 32'd1);
      in_valid[0] = 1'b1; in_data[0] = 8'hF0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t6_mux_s_mid", 32'(mux_s[0]), 32'd4);
      check("t6_ser_valid_mid", 32'(ser_valid[0]), 32'd1);
      rst[0] = 1'b1;
      #1;
      check("t6_rst_ser_valid", 32'(ser_valid[0]), 32'd0);
      check("t6_rst_ser_last", 32'(ser_last[0]), 32'd0);
      @(posedge clk); #1;
      rst[0] = 1'b0;
      @(negedge clk);
      check("t6_in_ready", 32'(in_ready[0]), 32'd1);
      check("t6_busy", 32'(busy[0]), 32'd0);
      check("t6_mux_s", 32'(mux_s[0]), 32'd0);
      check("t6_mux_i", 32'(mux_i[0]), 32'd0);
      check("t6_ser_valid", 32'(ser_valid[0]), 32'd0);
      $display("[TB] dut0 reset mid-word, in_ready=%0b mux_s=%0d", in_ready[0], mux_s[0]);
      @(posedge clk); #1;
      ser_ready[0] = 1'b0;

      // IDLE_GAP=2 instance: directed word, then randomized words across all instances.
      send_word(2, 8'h96, 0, 1'b0);
      for (int i = 0; i < 30; i++) begin
         send_word(int'($urandom_range(0, 2)), 8'($urandom), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
